// File: rtl/orient_hist_acc_if.sv
// Stream interface for orient_hist_acc.
//   Sample side : s_valid/s_ready handshake carrying s_bin (5b direction bin),
//                 s_mag (MAG_W magnitude weight) and s_last (end of window).
//   Result side : m_valid/m_ready handshake carrying m_bin (peak index),
//                 m_peak (ACC_W peak value) and m_count (16b sample count).
// Modport slave is the accumulator's view; master is the producer/consumer view.
interface orient_hist_acc_if #(
  parameter int unsigned MAG_W = 8,
  parameter int unsigned ACC_W = 16
);
  logic             s_valid;
  logic             s_ready;
  logic [4:0]       s_bin;
  logic [MAG_W-1:0] s_mag;
  logic             s_last;
  logic             m_valid;
  logic             m_ready;
  logic [4:0]       m_bin;
  logic [ACC_W-1:0] m_peak;
  logic [15:0]      m_count;

  modport slave (
    input  s_valid, s_bin, s_mag, s_last, m_ready,
    output s_ready, m_valid, m_bin, m_peak, m_count
  );

  modport master (
    output s_valid, s_bin, s_mag, s_last, m_ready,
    input  s_ready, m_valid, m_bin, m_peak, m_count
  );
endinterface

// File: rtl/orient_hist_acc.sv
// Orientation histogram accumulator with peak search.
// Accumulates weighted samples into 32 saturating direction bins until a
// sample flagged s_last, then scans bins 0..31 (one per cycle) for the
// strictly-greatest value (lowest index wins ties) and presents the result
// until accepted, after which the histogram is cleared for the next window.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - orient_hist_acc_if.slave (sample input / result output streams)
// Build option: define ORIENT_HIST_SMOOTH_EN to compare the circular
// [1 2 1]/4 smoothed bin value during the scan instead of the raw value.
module orient_hist_acc #(
  parameter int unsigned MAG_W = 8,
  parameter int unsigned ACC_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  orient_hist_acc_if.slave  bus
);

  typedef enum logic [1:0] {ST_ACC, ST_SCAN, ST_OUT} state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] bins_q [32];
  logic [15:0]      cnt_q;
  logic [4:0]       idx_q;
  logic [ACC_W-1:0] max_val_q;
  logic [4:0]       max_bin_q;

  logic             s_ready;
  logic             m_valid;
  logic             accept;
  logic             clear;
  logic [ACC_W:0]   add_full;
  logic [ACC_W-1:0] bin_d;
  logic [ACC_W-1:0] scan_val;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_ACC;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ACC:  if (accept && bus.s_last) state_d = ST_SCAN;
      ST_SCAN: if (idx_q == 5'd31)       state_d = ST_OUT;
      ST_OUT:  if (bus.m_ready)          state_d = ST_ACC;
      default: state_d = ST_ACC;
    endcase
  end

  // Output logic
  always_comb begin
    s_ready = 1'b0;
    m_valid = 1'b0;
    unique case (state_q)
      ST_ACC:  s_ready = 1'b1;
      ST_OUT:  m_valid = 1'b1;
      default: ;
    endcase
  end

  assign accept = bus.s_valid && s_ready;
  assign clear  = m_valid && bus.m_ready;

  // One extra bit catches overflow for saturation.
  assign add_full = {1'b0, bins_q[bus.s_bin]} + {{(ACC_W + 1 - MAG_W){1'b0}}, bus.s_mag};
  assign bin_d    = add_full[ACC_W] ? '1 : add_full[ACC_W-1:0];

`ifdef ORIENT_HIST_SMOOTH_EN
  logic [4:0]       idx_prev;
  logic [4:0]       idx_next;
  logic [ACC_W+1:0] smooth_sum;

  // 5-bit index arithmetic wraps mod 32, giving the circular neighbours.
  assign idx_prev   = idx_q - 5'd1;
  assign idx_next   = idx_q + 5'd1;
  assign smooth_sum = {2'b00, bins_q[idx_prev]} + {1'b0, bins_q[idx_q], 1'b0}
                    + {2'b00, bins_q[idx_next]};
  assign scan_val   = smooth_sum[ACC_W+1:2];
`else
  assign scan_val   = bins_q[idx_q];
`endif

  // Histogram, sample count and running-max datapath
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int unsigned i = 0; i < 32; i++) bins_q[i] <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      max_val_q <= '0;
      max_bin_q <= '0;
    end else begin
      if (accept) begin
        bins_q[bus.s_bin] <= bin_d;
        if (cnt_q != '1) cnt_q <= cnt_q + 16'd1;
      end
      // idx_q wraps back to 0 on the final scan step.
      if (state_q == ST_SCAN) begin
        idx_q <= idx_q + 5'd1;
        if (scan_val > max_val_q) begin
          max_val_q <= scan_val;
          max_bin_q <= idx_q;
        end
      end
    end
  end

  assign bus.s_ready = s_ready;
  assign bus.m_valid = m_valid;
  assign bus.m_bin   = max_bin_q;
  assign bus.m_peak  = max_val_q;
  assign bus.m_count = cnt_q;

endmodule

// File: tb/tb_orient_hist_acc.sv
// Directed self-checking bench for orient_hist_acc.
// u_dut uses default widths; u_sat uses ACC_W=8 for the saturation case.
// Expected values are hand-computed for both raw and smoothed builds.
module tb_orient_hist_acc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  orient_hist_acc_if #(.MAG_W(8), .ACC_W(16)) bus_a ();
  orient_hist_acc_if #(.MAG_W(8), .ACC_W(8))  bus_b ();

  orient_hist_acc #(.MAG_W(8), .ACC_W(16)) u_dut (.clk(clk), .rst(rst), .bus(bus_a));
  orient_hist_acc #(.MAG_W(8), .ACC_W(8))  u_sat (.clk(clk), .rst(rst), .bus(bus_b));

  int unsigned err_cnt = 0;
  int unsigned chk_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_a(input logic [4:0] b, input logic [7:0] m, input logic l);
    bus_a.s_valid = 1'b1; bus_a.s_bin = b; bus_a.s_mag = m; bus_a.s_last = l;
    tick();
    bus_a.s_valid = 1'b0; bus_a.s_last = 1'b0;
  endtask

  // Called right after the accept edge of the last sample; returns latency
  // measured in cycles from the accept cycle to the first m_valid cycle.
  task automatic wait_valid_a(output int lat);
    int n = 0;
    while (!bus_a.m_valid && n < 100) begin tick(); n++; end
    lat = n + 1;
  endtask

  task automatic handshake_a();
    bus_a.m_ready = 1'b1;
    tick();
    bus_a.m_ready = 1'b0;
    check("hs_mvalid_low", bus_a.m_valid, 0);
    check("hs_sready_high", bus_a.s_ready, 1);
  endtask

  // Runs a window of up to 3 samples and checks the result fields.
  task automatic window_a(input string tag, input int ns,
                          input logic [4:0] b0, input logic [7:0] m0,
                          input logic [4:0] b1, input logic [7:0] m1,
                          input logic [4:0] b2, input logic [7:0] m2,
                          input int exp_bin, input int exp_peak);
    int lat;
    if (ns >= 3) send_a(b2, m2, 1'b0);
    if (ns >= 2) send_a(b1, m1, 1'b0);
    send_a(b0, m0, 1'b1);
    check({tag, "_sready_scan"}, bus_a.s_ready, 0);
    wait_valid_a(lat);
    check({tag, "_latency"}, lat, 33);
    check({tag, "_bin"}, bus_a.m_bin, exp_bin);
    check({tag, "_peak"}, bus_a.m_peak, exp_peak);
    check({tag, "_count"}, bus_a.m_count, ns);
  endtask

  initial begin
    int n;
    bus_a.s_valid = 0; bus_a.s_bin = 0; bus_a.s_mag = 0; bus_a.s_last = 0; bus_a.m_ready = 0;
    bus_b.s_valid = 0; bus_b.s_bin = 0; bus_b.s_mag = 0; bus_b.s_last = 0; bus_b.m_ready = 0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_sready", bus_a.s_ready, 1);
    check("rst_mvalid", bus_a.m_valid, 0);
    check("rst_mbin", bus_a.m_bin, 0);
    check("rst_mpeak", bus_a.m_peak, 0);
    check("rst_mcount", bus_a.m_count, 0);

    // Basic: bins 5=30, 9=25. Smoothed: bin5=60/4=15, bin9=50/4=12.
`ifdef ORIENT_HIST_SMOOTH_EN
    window_a("basic", 3, 5'd9, 8'd25, 5'd5, 8'd20, 5'd5, 8'd10, 5, 15);
`else
    window_a("basic", 3, 5'd9, 8'd25, 5'd5, 8'd20, 5'd5, 8'd10, 5, 30);
`endif
    handshake_a();

    // Tie: bins 12=7, 3=7 -> lowest index. Smoothed: 14/4=3 at both.
`ifdef ORIENT_HIST_SMOOTH_EN
    window_a("tie", 2, 5'd3, 8'd7, 5'd12, 8'd7, 5'd0, 8'd0, 3, 3);
`else
    window_a("tie", 2, 5'd3, 8'd7, 5'd12, 8'd7, 5'd0, 8'd0, 3, 7);
`endif

    // Backpressure: result held, samples ignored.
    for (int i = 0; i < 10; i++) begin
      bus_a.s_valid = (i % 2) == 0; bus_a.s_bin = 5'd3; bus_a.s_mag = 8'd100;
      tick();
      check("bp_mvalid", bus_a.m_valid, 1);
      check("bp_sready", bus_a.s_ready, 0);
      check("bp_mbin", bus_a.m_bin, 3);
`ifdef ORIENT_HIST_SMOOTH_EN
      check("bp_mpeak", bus_a.m_peak, 3);
`else
      check("bp_mpeak", bus_a.m_peak, 7);
`endif
      check("bp_mcount", bus_a.m_count, 2);
    end
    bus_a.s_valid = 1'b0;
    handshake_a();
    check("clr_mcount", bus_a.m_count, 0);

    // Fresh window from cleared bins: bin3=4 only. Smoothed: 8/4=2.
`ifdef ORIENT_HIST_SMOOTH_EN
    window_a("fresh", 1, 5'd3, 8'd4, 5'd0, 8'd0, 5'd0, 8'd0, 3, 2);
`else
    window_a("fresh", 1, 5'd3, 8'd4, 5'd0, 8'd0, 5'd0, 8'd0, 3, 4);
`endif
    handshake_a();

    // Wrap: bins 0=40, 31=40. Smoothed: both 120/4=30; raw: tie 40 -> bin 0.
`ifdef ORIENT_HIST_SMOOTH_EN
    window_a("wrap", 2, 5'd31, 8'd40, 5'd0, 8'd40, 5'd0, 8'd0, 0, 30);
`else
    window_a("wrap", 2, 5'd31, 8'd40, 5'd0, 8'd40, 5'd0, 8'd0, 0, 40);
`endif
    handshake_a();

    // All-zero histogram.
    window_a("zero", 1, 5'd4, 8'd0, 5'd0, 8'd0, 5'd0, 8'd0, 0, 0);
    handshake_a();

    // Mid-scan reset: after the accept edge the DUT is on scan cycle 0.
    send_a(5'd7, 8'd50, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check("ms_mvalid_scan", bus_a.m_valid, 0);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("ms_sready", bus_a.s_ready, 1);
    check("ms_mcount", bus_a.m_count, 0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus_a.m_valid) n++;
      tick();
    end
    check("ms_never_valid", n, 0);
    // Smoothed single bin of 1: 2/4=0 -> all zero.
`ifdef ORIENT_HIST_SMOOTH_EN
    window_a("ms_fresh", 1, 5'd2, 8'd1, 5'd0, 8'd0, 5'd0, 8'd0, 0, 0);
`else
    window_a("ms_fresh", 1, 5'd2, 8'd1, 5'd0, 8'd0, 5'd0, 8'd0, 2, 1);
`endif
    handshake_a();

    // Saturation on the ACC_W=8 instance: 3 x 200 -> 255. Smoothed: 510/4=127.
    for (int i = 0; i < 3; i++) begin
      bus_b.s_valid = 1'b1; bus_b.s_bin = 5'd31; bus_b.s_mag = 8'd200; bus_b.s_last = (i == 2);
      tick();
    end
    bus_b.s_valid = 1'b0; bus_b.s_last = 1'b0;
    n = 0;
    while (!bus_b.m_valid && n < 100) begin tick(); n++; end
    check("sat_latency", n + 1, 33);
    check("sat_bin", bus_b.m_bin, 31);
`ifdef ORIENT_HIST_SMOOTH_EN
    check("sat_peak", bus_b.m_peak, 127);
`else
    check("sat_peak", bus_b.m_peak, 255);
`endif
    check("sat_count", bus_b.m_count, 3);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/orient_hist_acc.md
ORIENT_HIST_ACC -- requirements
Module: orient_hist_acc

Interface
REQ-001 SHALL have parameter MAG_W, default 8, gradient-magnitude width in bits.
REQ-002 SHALL have parameter ACC_W, default 16, histogram-bin accumulator width in bits (ACC_W >= MAG_W).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port s_valid  input  1  sample valid.
REQ-006 SHALL have port s_ready  output  1  block can accept a sample.
REQ-007 SHALL have port s_bin  input  5  direction bin 0..31 from the 5-bit direction lookup stage.
REQ-008 SHALL have port s_mag  input  MAG_W  unsigned gradient-magnitude weight.
REQ-009 SHALL have port s_last  input  1  marks the final sample of a keypoint window.
REQ-010 SHALL have port m_valid  output  1  result valid.
REQ-011 SHALL have port m_ready  input  1  downstream accepts result.
REQ-012 SHALL have port m_bin  output  5  index of peak bin.
REQ-013 SHALL have port m_peak  output  ACC_W  value of peak bin.
REQ-014 SHALL have port m_count  output  16  number of samples accepted in the window (saturating at 65535).

Function
REQ-015 SHALL hold 32 bin registers of ACC_W bits and a 3-state FSM: ACC, SCAN, OUT.
REQ-016 SHALL assert s_ready only in ACC; a sample is accepted when s_valid && s_ready.
REQ-017 SHALL, on accept, add s_mag to bin[s_bin] with saturation at 2^ACC_W-1, visible the next cycle; one sample per cycle, back-to-back supported.
REQ-018 SHALL, on accept, increment m_count (saturating).
REQ-019 SHALL transition ACC->SCAN on the cycle after an accepted sample with s_last=1; that sample is accumulated before scanning.
REQ-020 SHALL in SCAN visit bins 0..31, one per cycle, exactly 32 cycles, keeping running max value and index.
REQ-021 SHALL update the running max only on strictly greater value; ties resolve to the lowest index; all-zero histogram yields m_bin=0, m_peak=0.
REQ-022 SHALL enter OUT after the 32nd scan cycle, asserting m_valid with m_bin/m_peak/m_count stable until m_ready.
REQ-023 SHALL give latency: s_last accepted at cycle T -> m_valid first high at cycle T+33.
REQ-024 SHALL, on the cycle m_valid && m_ready, clear all 32 bins, m_count and the running max, and return to ACC (s_ready high next cycle).
REQ-025 SHALL ignore s_valid/s_bin/s_mag/s_last in SCAN and OUT (s_ready low, no bin change).
REQ-026 SHALL hold m_valid low in ACC and SCAN; m_ready is ignored outside OUT.

Reset
REQ-027 SHALL on rst=1 at a clock edge clear all bins, m_count, running max, set FSM to ACC, m_valid=0, m_bin=0, m_peak=0, s_ready=1 on the following cycle.
REQ-028 SHALL abandon any in-progress window or scan on mid-operation reset; rst has priority over all handshakes in the same cycle.

Configuration
REQ-029 SHALL support macro ORIENT_HIST_SMOOTH_EN.
REQ-030 SHALL, with ORIENT_HIST_SMOOTH_EN defined, compare during SCAN the circularly smoothed value (bin[i-1] + 2*bin[i] + bin[i+1]) >> 2 with indices mod 32, computed at ACC_W+2 bits, reported in m_peak; latency unchanged.
REQ-031 SHALL, without ORIENT_HIST_SMOOTH_EN, compare raw bin values; no smoothing logic present.

Verification
REQ-032 SHALL cover: reset, then samples (bin 5, mag 10), (bin 5, mag 20), (bin 9, mag 25, last) -> m_bin=5, m_peak=30, m_count=3, m_valid exactly 33 cycles after last accept (smoothing off).
REQ-033 SHALL cover tie: (bin 12, mag 7), (bin 3, mag 7, last) -> m_bin=3, m_peak=7.
REQ-034 SHALL cover saturation with ACC_W=8, MAG_W=8: 3 samples bin 31 mag 200 -> m_peak=255, m_bin=31.
REQ-035 SHALL cover backpressure: hold m_ready=0 for 10 cycles in OUT -> outputs stable, s_ready=0, s_valid pulses ignored; after handshake next window starts from cleared bins.
REQ-036 SHALL cover wrap smoothing (SMOOTH_EN): (bin 0, mag 40), (bin 31, mag 40, last) -> m_bin=0, m_peak=30.
REQ-037 SHALL cover mid-scan reset: rst at SCAN cycle 10 -> m_valid never asserted, s_ready=1 next cycle, fresh window single sample (bin 2, mag 1, last) -> m_bin=2, m_peak=1, m_count=1.
